// File: rtl/ysyx_220066_ifu_resp.sv
// ysyx_220066_ifu_resp: instruction-fetch responder with a fixed-latency read pipeline and a credit-limited response FIFO.
module ysyx_220066_ifu_resp #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_pc,
  input  logic        flush,
  output logic [63:0] mem_raddr,
  output logic        mem_ren,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_pc,
  output logic [31:0] resp_inst,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW:0]   occ, fcnt;
  logic [AW-1:0] wp, rp;
  logic          sv   [1:LATENCY];
  logic          serr [1:LATENCY];
  logic [63:0]   spc  [1:LATENCY];
  logic [63:0]   fpc   [DEPTH];
  logic [31:0]   finst [DEPTH];
  logic          ferr  [DEPTH];
  logic          accept, pop, fpop, push, fempty;
  logic [31:0]   s1_inst, last_inst;
  assign req_ready  = ~flush & (occ < FULL);
  assign accept     = req_valid & req_ready;
  assign mem_ren    = accept & ~rst & (req_pc[1:0] == 2'b00);
  assign mem_raddr  = {req_pc[63:3], 3'b000};
  assign s1_inst    = serr[1] ? 32'h0 : spc[1][2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign fempty     = fcnt == '0;
  assign resp_valid = ~fempty | sv[LATENCY];
  assign pop        = resp_valid & resp_ready & ~flush;
  assign fpop       = pop & ~fempty;
  // With an empty FIFO the last stage is presented directly; it is queued only if not taken.
  assign push       = sv[LATENCY] & ~(fempty & resp_ready);
  assign resp_pc    = ~fempty ? fpc[rp]   : sv[LATENCY] ? spc[LATENCY] : 64'h0;
  assign resp_inst  = ~fempty ? finst[rp] : sv[LATENCY] ? last_inst    : 32'h0;
  assign resp_err   = ~fempty ? ferr[rp]  : sv[LATENCY] & serr[LATENCY];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= '0;
      fcnt <= '0;
      wp   <= '0;
      rp   <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        sv[k]   <= 1'b0;
        serr[k] <= 1'b0;
        spc[k]  <= 64'h0;
      end
    end else begin
      occ     <= flush ? '0 : occ + (AW+1)'(accept) - (AW+1)'(pop);
      fcnt    <= flush ? '0 : fcnt + (AW+1)'(push) - (AW+1)'(fpop);
      wp      <= flush ? '0 : wp + AW'(push);
      rp      <= flush ? '0 : rp + AW'(fpop);
      sv[1]   <= accept;
      spc[1]  <= req_pc;
      serr[1] <= |req_pc[1:0];
      for (int k = 2; k <= LATENCY; k++) begin
        sv[k]   <= sv[k-1] & ~flush;
        spc[k]  <= spc[k-1];
        serr[k] <= serr[k-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fpc[wp]   <= spc[LATENCY];
      finst[wp] <= last_inst;
      ferr[wp]  <= serr[LATENCY];
    end
  end
  generate
    if (LATENCY == 1) begin : g_direct
      assign last_inst = s1_inst;
    end else begin : g_delay
      logic [31:0] iq [2:LATENCY];
      always_ff @(posedge clk) begin
        iq[2] <= s1_inst;
        for (int k = 3; k <= LATENCY; k++) iq[k] <= iq[k-1];
      end
      assign last_inst = iq[LATENCY];
    end
  endgenerate
endmodule

// File: tb/tb_ysyx_220066_ifu_resp.sv
// tb_ysyx_220066_ifu_resp: directed vector table plus hand-written flush/backpressure/reset sequences.
module tb_ysyx_220066_ifu_resp;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, flush = 1'b0, mem_ren, resp_valid, resp_ready = 1'b1, resp_err;
  logic [63:0] req_pc = 64'h0, mem_raddr, mem_rdata = 64'h0, resp_pc;
  logic [31:0] resp_inst;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_220066_ifu_resp #(.LATENCY(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .flush(flush), .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
    .resp_inst(resp_inst), .resp_err(resp_err)
  );
  function automatic logic [63:0] word(input logic [63:0] a);
    return a == 64'h8000_0000 ? 64'h0000_0013_0000_0093 : {~a[31:0], a[31:0]};
  endfunction
  always @(posedge clk) if (mem_ren) mem_rdata <= word(mem_raddr);
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [63:0] pc, input logic rr, input logic fl);
    req_valid = v;
    req_pc = pc;
    resp_ready = rr;
    flush = fl;
    #3;
  endtask
  typedef struct {
    logic v; logic [63:0] pc; logic rr;
    logic rdy; logic ren; logic [63:0] addr; logic rv; logic [63:0] rpc; logic [31:0] inst; logic err;
  } vec_t;
  vec_t tv [12];
  logic [31:0] e3 [4];
  initial begin
    tv[0]  = '{1'b1, 64'h8000_0000, 1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 64'h8000_0004, 1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 32'h0, 1'b0};
    tv[2]  = '{1'b1, 64'h8000_0002, 1'b1, 1'b1, 1'b0, 64'h8000_0000, 1'b1, 64'h8000_0000, 32'h0000_0093, 1'b0};
    tv[3]  = '{1'b1, 64'h8000_0008, 1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h0000_0013, 1'b0};
    tv[4]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0002, 32'h0, 1'b1};
    tv[5]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0008, 32'h8000_0008, 1'b0};
    tv[6]  = '{1'b1, 64'h8000_0010, 1'b0, 1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0, 32'h0, 1'b0};
    tv[7]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0};
    tv[8]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0010, 32'h8000_0010, 1'b0};
    tv[9]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0010, 32'h8000_0010, 1'b0};
    tv[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0010, 32'h8000_0010, 1'b0};
    tv[11] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0};
    e3 = '{32'h8000_0100, 32'h7FFF_FEFF, 32'h8000_0108, 32'h7FFF_FEF7};
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(resp_valid), 64'h0);
    chk("rst_pc", resp_pc, 64'h0);
    chk("rst_inst", 64'(resp_inst), 64'h0);
    chk("rst_err", 64'(resp_err), 64'h0);
    chk("rst_ren", 64'(mem_ren), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h1);
    cyc;
    cyc;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc;
      drive(tv[i].v, tv[i].pc, tv[i].rr, 1'b0);
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tv[i].rdy));
      chk($sformatf("v%0d_ren", i), 64'(mem_ren), 64'(tv[i].ren));
      if (tv[i].v) chk($sformatf("v%0d_addr", i), mem_raddr, tv[i].addr);
      chk($sformatf("v%0d_rvalid", i), 64'(resp_valid), 64'(tv[i].rv));
      if (tv[i].rv) begin
        chk($sformatf("v%0d_rpc", i), resp_pc, tv[i].rpc);
        chk($sformatf("v%0d_rinst", i), 64'(resp_inst), 64'(tv[i].inst));
        chk($sformatf("v%0d_rerr", i), 64'(resp_err), 64'(tv[i].err));
      end
    end
    for (int i = 0; i < 6; i++) begin
      cyc;
      drive(1'b1, 64'h8000_0100 + 64'(4 * i), 1'b0, 1'b0);
      chk($sformatf("credit%0d_ready", i), 64'(req_ready), 64'(i < 4));
    end
    for (int j = 0; j < 4; j++) begin
      cyc;
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      chk($sformatf("drain%0d_valid", j), 64'(resp_valid), 64'h1);
      chk($sformatf("drain%0d_pc", j), resp_pc, 64'h8000_0100 + 64'(4 * j));
      chk($sformatf("drain%0d_inst", j), 64'(resp_inst), 64'(e3[j]));
      if (j < 2) chk($sformatf("drain%0d_ready", j), 64'(req_ready), 64'(j));
    end
    cyc;
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    chk("drain_empty", 64'(resp_valid), 64'h0);
    cyc; drive(1'b1, 64'h8000_0200, 1'b1, 1'b0);
    cyc; drive(1'b1, 64'h8000_0204, 1'b1, 1'b0);
    cyc; drive(1'b1, 64'h8000_0208, 1'b1, 1'b0);
    cyc; drive(1'b1, 64'h8000_020C, 1'b1, 1'b1);
    chk("flush_ready", 64'(req_ready), 64'h0);
    chk("flush_ren", 64'(mem_ren), 64'h0);
    for (int i = 0; i < 6; i++) begin
      cyc;
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      chk($sformatf("flush_stale%0d", i), 64'(resp_valid), 64'h0);
    end
    cyc; drive(1'b1, 64'h8000_0300, 1'b1, 1'b0);
    chk("post_flush_ren", 64'(mem_ren), 64'h1);
    cyc; drive(1'b0, 64'h0, 1'b1, 1'b0);
    cyc; drive(1'b0, 64'h0, 1'b1, 1'b0);
    chk("post_flush_valid", 64'(resp_valid), 64'h1);
    chk("post_flush_pc", resp_pc, 64'h8000_0300);
    chk("post_flush_inst", 64'(resp_inst), 64'h8000_0300);
    chk("post_flush_err", 64'(resp_err), 64'h0);
    cyc; drive(1'b0, 64'h0, 1'b1, 1'b0);
    chk("post_flush_empty", 64'(resp_valid), 64'h0);
    cyc; drive(1'b1, 64'h8000_0400, 1'b0, 1'b0);
    cyc; drive(1'b1, 64'h8000_0408, 1'b0, 1'b0);
    cyc; drive(1'b1, 64'h8000_0410, 1'b0, 1'b0);
    chk("burst_valid", 64'(resp_valid), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(resp_valid), 64'h0);
    chk("arst_ren", 64'(mem_ren), 64'h0);
    chk("arst_ready", 64'(req_ready), 64'h1);
    cyc;
    cyc;
    #2 rst = 1'b0;
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk($sformatf("arst_quiet%0d", i), 64'(resp_valid), 64'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
